// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports,
// a per-register busy scoreboard, and optional same-cycle write forwarding.

// One read port. It looks up stored data and busy state, then optionally
// overrides them with this cycle's write data.
module regfile_mp_rdport #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic [AW-1:0]                ra_i,
    input  logic [NREGS-1:0][XLEN-1:0]   regs_i,
    input  logic [NREGS-1:0]             busy_i,
    input  logic                         wen0_i,
    input  logic [AW-1:0]                wa0_i,
    input  logic [XLEN-1:0]              wd0_i,
    input  logic                         wen1_i,
    input  logic [AW-1:0]                wa1_i,
    input  logic [XLEN-1:0]              wd1_i,
    input  logic                         rsv_i,
    input  logic [AW-1:0]                rsv_addr_i,
    output logic [XLEN-1:0]              rd_o,
    output logic                         rbusy_o
);
    logic hit0, hit1;

    // wen*_i already exclude register 0, so a hit never forwards into r0.
    assign hit0 = (BYPASS != 0) && wen0_i && (wa0_i == ra_i);
    assign hit1 = (BYPASS != 0) && wen1_i && (wa1_i == ra_i);

    // Stored value by default; forwarded data with port 1 ahead of port 0.
    always_comb begin
        rd_o    = regs_i[ra_i];
        rbusy_o = busy_i[ra_i];
        if (hit1)
            rd_o = wd1_i;
        else if (hit0)
            rd_o = wd0_i;
        // A forwarded write retires the pending result, unless a new
        // reservation lands on the same register this cycle.
        if (hit0 || hit1)
            rbusy_o = rsv_i && (rsv_addr_i == ra_i);
    end
endmodule

module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic [NRD-1:0]        rbusy
);
    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic                       wen0, wen1, rsv;

    // Qualified strobes: nothing takes effect during reset or on register 0.
    assign wen0 = we0    && !reset && (wa0 != '0);
    assign wen1 = we1    && !reset && (wa1 != '0);
    assign rsv  = rsv_en && !reset && (rsv_addr != '0);

    // Next state: port 0 write, then port 1 (wins on collision), then the
    // reservation, which overrides the busy-clear of a same-address write.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wen0) begin
            regs_d[wa0] = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (wen1) begin
            regs_d[wa1] = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (rsv)
            busy_d[rsv_addr] = 1'b1;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports depend only on state and write-side inputs; ra never
    // reaches the next-state logic.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_mp_rdport #(
            .XLEN(XLEN), .NREGS(NREGS), .BYPASS(BYPASS)
        ) u_rd (
            .ra_i       (ra[k*AW +: AW]),
            .regs_i     (regs_q),
            .busy_i     (busy_q),
            .wen0_i     (wen0),
            .wa0_i      (wa0),
            .wd0_i      (wd0),
            .wen1_i     (wen1),
            .wa1_i      (wa1),
            .wd1_i      (wd1),
            .rsv_i      (rsv),
            .rsv_addr_i (rsv_addr),
            .rd_o       (rd[k*XLEN +: XLEN]),
            .rbusy_o    (rbusy[k])
        );
    end
endmodule
